// File: rtl/vproc_div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : vproc_div_iter
//  Function : Iterative restoring integer divider (DIV/DIVU/REM/REMU).
//             Resolves UNROLL quotient bits per cycle, WIDTH/UNROLL cycles
//             per operation, with valid/ready handshakes on both sides,
//             flush and a pass-through tag.
//  Options  : VPROC_DIV_EARLY_OUT_EN - retire divide-by-zero and signed
//             overflow directly from PREP instead of iterating.
//  Revision : 1.0 - initial release
// ============================================================================
module vproc_div_iter #(
    parameter int WIDTH  = 32,
    parameter int UNROLL = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk_i,
    input  logic             sync_rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             signed_i,
    input  logic             mod_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             flush_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] res_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int C_N     = WIDTH / UNROLL;
    localparam int C_CNT_W = (C_N > 1) ? $clog2(C_N) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_ITER  = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic               r_signed;
    logic               r_mod;
    logic [TAG_W-1:0]   r_tag;
    logic [WIDTH-1:0]   r_a;        // |dividend|, shifted into quotient bits
    logic [WIDTH-1:0]   r_b;        // |divisor|
    logic [WIDTH:0]     r_rem;      // partial remainder, one guard bit
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_div0;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_res;
    logic [TAG_W-1:0]   r_tag_out;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_accept;
    logic               w_op1_neg;
    logic               w_op2_neg;
    logic [WIDTH-1:0]   w_abs1;
    logic [WIDTH-1:0]   w_abs2;
    logic               w_div0;
    logic               w_ovf;
    logic [WIDTH:0]     w_rem_nxt;
    logic [WIDTH-1:0]   w_q_nxt;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Result for the two architecturally defined corner cases; only
    // meaningful when div0 or overflow is set.
    function automatic logic [WIDTH-1:0] f_special(input logic div0,
                                                   input logic md,
                                                   input logic [WIDTH-1:0] op1);
        if (div0) begin
            return md ? op1 : {WIDTH{1'b1}};
        end
        return md ? {WIDTH{1'b0}} : op1;
    endfunction

    // Flush blocks new requests so an abort can never be raced by an accept.
    assign w_in_ready = !flush_i && ((r_state == S_IDLE) ||
                                     ((r_state == S_DONE) && out_ready_i));
    assign w_accept   = in_valid_i && w_in_ready;

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = r_out_valid;
    assign res_o       = r_res;
    assign tag_o       = r_tag_out;

    // Operand magnitudes and corner-case detection from the latched request.
    always_comb begin
        w_op1_neg = r_signed && r_op1[WIDTH-1];
        w_op2_neg = r_signed && r_op2[WIDTH-1];
        w_abs1    = w_op1_neg ? -r_op1 : r_op1;
        w_abs2    = w_op2_neg ? -r_op2 : r_op2;
        w_div0    = (r_op2 == '0);
        w_ovf     = r_signed && (r_op1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (r_op2 == {WIDTH{1'b1}});
    end

    // UNROLL chained restoring steps: shift in the next dividend bit, subtract
    // the divisor when it fits and record the quotient bit.
    always_comb begin
        w_rem_nxt = r_rem;
        w_q_nxt   = r_a;
        for (int i = 0; i < UNROLL; i++) begin
            w_rem_nxt = {w_rem_nxt[WIDTH-1:0], w_q_nxt[WIDTH-1]};
            w_q_nxt   = {w_q_nxt[WIDTH-2:0], 1'b0};
            if (w_rem_nxt >= {1'b0, r_b}) begin
                w_rem_nxt  = w_rem_nxt - {1'b0, r_b};
                w_q_nxt[0] = 1'b1;
            end
        end
    end

    // Sign correction of the unsigned quotient and remainder.
    always_comb begin
        w_quo_fix = r_qneg ? -r_a : r_a;
        w_rem_fix = r_rneg ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
    end

    // Capture the request on every accepted handshake.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_op1    <= '0;
            r_op2    <= '0;
            r_signed <= 1'b0;
            r_mod    <= 1'b0;
            r_tag    <= '0;
        end else if (w_accept) begin
            r_op1    <= op1_i;
            r_op2    <= op2_i;
            r_signed <= signed_i;
            r_mod    <= mod_i;
            r_tag    <= tag_i;
        end
    end

    // Control FSM and datapath registers; flush returns to IDLE from anywhere.
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_qneg      <= 1'b0;
            r_rneg      <= 1'b0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_res       <= '0;
            r_tag_out   <= '0;
            r_out_valid <= 1'b0;
        end else if (flush_i) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_PREP;
                    end
                end
                S_PREP: begin
                    r_a    <= w_abs1;
                    r_b    <= w_abs2;
                    r_qneg <= w_op1_neg ^ w_op2_neg;
                    r_rneg <= w_op1_neg;
                    r_div0 <= w_div0;
                    r_ovf  <= w_ovf;
                    r_rem  <= '0;
                    r_cnt  <= C_CNT_W'(C_N - 1);
`ifdef VPROC_DIV_EARLY_OUT_EN
                    if (w_div0 || w_ovf) begin
                        r_res       <= f_special(w_div0, r_mod, r_op1);
                        r_tag_out   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state <= S_ITER;
                    end
`else
                    r_state <= S_ITER;
`endif
                end
                S_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_a   <= w_q_nxt;
                    if (r_cnt == '0) begin
                        r_state <= S_FIXUP;
                    end else begin
                        r_cnt <= r_cnt - C_CNT_W'(1);
                    end
                end
                S_FIXUP: begin
                    if (r_div0 || r_ovf) begin
                        r_res <= f_special(r_div0, r_mod, r_op1);
                    end else begin
                        r_res <= r_mod ? w_rem_fix : w_quo_fix;
                    end
                    r_tag_out   <= r_tag;
                    r_out_valid <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_state     <= w_accept ? S_PREP : S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/vproc_div_iter.md
# vproc_div_iter

Iterative, parametrised integer divider for the vector execution unit, implementing RISC-V DIV/DIVU/REM/REMU semantics for any operand width. It accepts one operation at a time through a valid/ready handshake and retires N = WIDTH/UNROLL restoring-division steps, one per cycle. It returns the quotient or remainder with a caller-supplied tag through an output handshake that tolerates backpressure. Unlike the single-cycle divider, it supports signed and unsigned modes, correct overflow handling, abort, and configurable throughput per cycle.

## Interface
- WIDTH, 32, operand/result width; even, >= 8
- UNROLL, 1, quotient bits resolved per cycle; 1, 2 or 4; must divide WIDTH
- TAG_W, 4, width of the pass-through tag
- clk_i  in  1  clock; all state updates on the rising edge
- sync_rst_ni  in  1  reset, synchronous, active-low
- in_valid_i  in  1  operation request
- in_ready_o  out  1  divider can accept a request
- signed_i  in  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU
- mod_i  in  1  0 = quotient, 1 = remainder
- op1_i  in  WIDTH  dividend
- op2_i  in  WIDTH  divisor
- tag_i  in  TAG_W  request tag
- flush_i  in  1  abort any in-flight operation
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer takes result
- res_o  out  WIDTH  quotient or remainder
- tag_o  out  TAG_W  tag of the reported result

## Operation
- States: IDLE, PREP, ITER, FIXUP, DONE. Reset state is IDLE.
- IDLE: in_ready_o=1. A handshake (in_valid_i & in_ready_o) latches operands, signed_i, mod_i and tag_i, then moves to PREP.
- PREP: stores absolute values of the operands and the result signs.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - In unsigned mode, both signs are positive.
  - Clears the partial remainder. Step counter is set to N-1. Moves to ITER.
- ITER: each cycle performs UNROLL shift/compare/subtract steps on the (WIDTH+1)-bit partial remainder and shifts in UNROLL quotient bits. When the counter reaches 0, moves to FIXUP.
- FIXUP: applies sign correction (two's-complement negate), selects quotient or remainder by mod_i, registers res_o and tag_o, then moves to DONE.
- DONE: out_valid_o=1; res_o and tag_o are held stable.
  - out_ready_i=1 moves to IDLE.
  - in_ready_o = out_ready_i in DONE, so a new request is accepted in the same cycle the result is consumed and the next state is PREP.
- Required results:
  - Divisor 0: quotient = all ones; remainder = op1.
  - Signed op1 = most-negative value with op2 = all ones: quotient = op1 (most-negative value); remainder = 0.
  - All other cases: quotient truncates toward zero; remainder has the dividend's sign and |rem| < |op2|.
- flush_i:
  - Next state is IDLE from any state.
  - out_valid_o is 0 the following cycle.
  - in_ready_o is forced to 0 while flush_i=1, so flush wins over a simultaneous request.
  - A result in DONE that is flushed is dropped.
- Reset:
  - sync_rst_ni=0 at an edge sets state to IDLE and clears res_o, tag_o and out_valid_o to 0.
  - Reset mid-operation discards the operation.
  - Reset has priority over flush_i and over the handshake.

## Timing
- Accept edge is cycle 0. PREP runs in cycle 1, ITER in cycles 2..N+1, FIXUP in cycle N+2. out_valid_o=1 from cycle N+3.
- With WIDTH=32: latency is 35 cycles for UNROLL=1 and 11 cycles for UNROLL=4.
- With out_ready_i held high, throughput is one operation every N+3 cycles.
- res_o, tag_o and out_valid_o are registered outputs.
- in_ready_o is combinational: it depends on state, out_ready_i and flush_i.
- No combinational path from any in_* input to any out_* output.

## Configuration
- VPROC_DIV_EARLY_OUT_EN defined:
  - Divide-by-zero and signed overflow are detected in PREP, and the FSM goes PREP to DONE with the correct result.
  - out_valid_o rises in cycle 2 after accept.
  - Non-special operations keep the full latency.
- Macro undefined: every operation takes N+3 cycles. Special-case results are forced in FIXUP and are bit-identical to the macro-defined results.

## Test plan
- Unsigned, WIDTH=32, UNROLL=1, op1=100, op2=7, out_ready_i=1:
  - mod=0 gives res=14 at cycle 35; mod=1 gives res=2.
  - Tag 0x5 is returned on tag_o.
- Signed, op1=-7, op2=2: quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed, op1=7, op2=-2: quotient -3, remainder 1.
- Divisor 0, op1=0x1234:
  - quotient 0xFFFFFFFF, remainder 0x1234.
  - Latency is 2 with VPROC_DIV_EARLY_OUT_EN defined, 35 without.
- Signed op1=0x80000000, op2=0xFFFFFFFF: quotient 0x80000000, remainder 0. Unsigned with the same operands: quotient 0, remainder 0x80000000.
- Backpressure: out_ready_i=0 for 10 cycles after out_valid_o rises, so res_o and tag_o hold. A second request is presented with out_ready_i=1 and is accepted in that same cycle; its result follows N+3 cycles later.
- flush_i at cycle 10 of an operation: no out_valid_o. A request asserted during the flush cycle is not accepted; a request one cycle later is accepted and completes correctly. Repeat with sync_rst_ni=0 mid-ITER: all outputs read 0.
